signed_bcd_converter: RTL and testbench

SIGNED_BCD_CONVERTER -- requirements
Module: signed_bcd_converter

---
 rtl/signed_bcd_converter_if.sv | 13 +
 rtl/signed_bcd_converter.sv | 65 ++++++
 tb/tb_signed_bcd_converter.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/signed_bcd_converter_if.sv
// signed_bcd_converter_if: request/result bundle for the signed BCD converter
interface signed_bcd_converter_if;
    logic       start;
    logic [7:0] value;
    logic       busy;
    logic       done;
    logic       sign;
    logic [3:0] hundreds;
    logic [3:0] tens;
    logic [3:0] ones;
    modport master (output start, value, input busy, done, sign, hundreds, tens, ones);
    modport slave (input start, value, output busy, done, sign, hundreds, tens, ones);
endinterface

// File: rtl/signed_bcd_converter.sv
// signed_bcd_converter: 8-bit two's-complement to sign + 3-digit BCD via double-dabble
module signed_bcd_converter (
    input logic clk,
    input logic rst_n,
    signed_bcd_converter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;
    state_t state_q, state_d;
    logic [7:0] mag;
    logic [11:0] scratch;
    logic [11:0] adj;
    logic [19:0] shifted;
    logic [2:0] cnt;
    logic sign_cap;
    logic sign_q;
    logic [3:0] hundreds_q, tens_q, ones_q;
    assign adj[3:0] = scratch[3:0] >= 4'd5 ? scratch[3:0] + 4'd3 : scratch[3:0];
    assign adj[7:4] = scratch[7:4] >= 4'd5 ? scratch[7:4] + 4'd3 : scratch[7:4];
    assign adj[11:8] = scratch[11:8] >= 4'd5 ? scratch[11:8] + 4'd3 : scratch[11:8];
    assign shifted = {adj, mag} << 1;
    assign bus.busy = state_q == CONVERT;
    assign bus.done = state_q == DONE;
    assign bus.sign = sign_q;
    assign bus.hundreds = hundreds_q;
    assign bus.tens = tens_q;
    assign bus.ones = ones_q;
    // next state: IDLE waits for start, CONVERT runs 8 iterations, DONE lasts one cycle
    always_comb begin
        state_d = state_q;
        state_d = state_q == IDLE ? (bus.start ? CONVERT : IDLE) :
                  state_q == CONVERT ? (cnt == 3'd7 ? DONE : CONVERT) : IDLE;
    end
    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else state_q <= state_d;
    end
    // capture operand, iterate the shift-add-3 datapath, publish the result on the last iteration
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_cap <= 1'b0;
            mag <= 8'd0;
            scratch <= 12'd0;
            cnt <= 3'd0;
            sign_q <= 1'b0;
            hundreds_q <= 4'd0;
            tens_q <= 4'd0;
            ones_q <= 4'd0;
        end else if (state_q == IDLE && bus.start) begin
            sign_cap <= bus.value[7];
            mag <= bus.value[7] ? ~bus.value + 8'd1 : bus.value;
            scratch <= 12'd0;
            cnt <= 3'd0;
        end else if (state_q == CONVERT) begin
            {scratch, mag} <= shifted;
            cnt <= cnt + 3'd1;
            if (cnt == 3'd7) begin
                sign_q <= sign_cap;
                hundreds_q <= shifted[19:16];
                tens_q <= shifted[15:12];
                ones_q <= shifted[11:8];
            end
        end
    end
endmodule

// File: tb/tb_signed_bcd_converter.sv
// tb_signed_bcd_converter: randomized self-checking bench against an arithmetic model
module tb_signed_bcd_converter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int errors = 0;
    int checks = 0;
    logic [12:0] last_exp = 13'd0;
    logic [12:0] result;
    signed_bcd_converter_if bus ();
    signed_bcd_converter dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    assign result = {bus.sign, bus.hundreds, bus.tens, bus.ones};
    always #5 clk = ~clk;

    function automatic logic [12:0] model(input logic [7:0] v);
        int s;
        int a;
        s = $signed(v);
        a = s < 0 ? -s : s;
        model = {s < 0, 4'(a / 100), 4'(a / 10 % 10), 4'(a % 10)};
    endfunction

    task automatic convert(input logic [7:0] v);
        logic [12:0] exp_r;
        exp_r = model(v);
        bus.start = 1'b1;
        bus.value = v;
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
                errors++;
                $display("FAIL convert_busy v=%h cyc=%0d busy=%b done=%b required busy=1 done=0", v, i, bus.busy, bus.done);
            end
            checks++;
            if (result !== last_exp) begin
                errors++;
                $display("FAIL convert_hold v=%h cyc=%0d got=%h required=%h", v, i, result, last_exp);
            end
            bus.value = 8'($urandom);
            bus.start = 1'($urandom);
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || result !== exp_r) begin
            errors++;
            $display("FAIL convert_done v=%h done=%b busy=%b got=%h required done=1 busy=0 res=%h", v, bus.done, bus.busy, result, exp_r);
        end
        last_exp = exp_r;
        @(posedge clk); #1;
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || result !== exp_r) begin
            errors++;
            $display("FAIL convert_after v=%h done=%b busy=%b got=%h required done=0 busy=0 res=%h", v, bus.done, bus.busy, result, exp_r);
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus.value = 8'h00;
        rst_n = 1'b0;
        #2;
        checks++;
        if ({bus.busy, bus.done, result} !== 15'd0) begin
            errors++;
            $display("FAIL reset_state got=%h required=0", {bus.busy, bus.done, result});
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_vectors();
        convert(8'h2A);
        convert(8'h80);
        convert(8'h7F);
        convert(8'hFF);
        convert(8'h00);
        convert(8'h9C);
    endtask

    task automatic test_idle_hold();
        bus.start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.value = 8'($urandom);
            @(posedge clk); #1;
            checks++;
            if (bus.busy !== 1'b0 || bus.done !== 1'b0 || result !== last_exp) begin
                errors++;
                $display("FAIL idle_hold busy=%b done=%b got=%h required=%h", bus.busy, bus.done, result, last_exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] cap;
        int phase;
        cap = 8'h00;
        bus.start = 1'b1;
        bus.value = 8'($urandom);
        for (int c = 0; c < 60; c++) begin
            phase = c % 10;
            if (phase == 0) cap = bus.value;
            @(posedge clk); #1;
            checks++;
            if (bus.done !== (phase == 8) || bus.busy !== (phase < 8)) begin
                errors++;
                $display("FAIL b2b_timing c=%0d done=%b busy=%b required done=%b busy=%b", c, bus.done, bus.busy, phase == 8, phase < 8);
            end
            if (phase == 8) begin
                checks++;
                if (result !== model(cap)) begin
                    errors++;
                    $display("FAIL b2b_result cap=%h got=%h required=%h", cap, result, model(cap));
                end
                last_exp = model(cap);
            end
            bus.value = 8'($urandom);
        end
        bus.start = 1'b0;
    endtask

    task automatic test_reset_abort();
        convert(8'h80);
        bus.start = 1'b1;
        bus.value = 8'($urandom);
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.done, result} !== 15'd0) begin
            errors++;
            $display("FAIL abort_clear got=%h required=0", {bus.busy, bus.done, result});
        end
        last_exp = 13'd0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL abort_nodone done=%b busy=%b required 0 0", bus.done, bus.busy);
            end
        end
        rst_n = 1'b1;
        convert(8'hC3);
    endtask

    task automatic test_sweep();
        for (int i = -128; i < 128; i++) convert(8'(i));
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_idle_hold();
        test_back_to_back();
        test_idle_hold();
        test_reset_abort();
        test_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
